// File: rtl/ps2_smg_ctrlmod.sv
// Display-ownership arbiter between PS/2 keycodes and a background word; outputs registered, 1-cycle latency, no backpressure (one iTrig per edge at most).
// Optional DUP_FILTER_EN: keycode repeats while the keyboard owns the display only extend the hold.
module ps2_smg_ctrlmod #(
   parameter int HOLD_CYC = 50_000_000
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        iTrig,
   input  logic [7:0]  iData,
   input  logic [2:0]  iTag,
   input  logic [23:0] iBgData,
   input  logic        iLock,
   output logic [23:0] oData,
   output logic [2:0]  oTag,
   output logic        oOwner,
   output logic [7:0]  oEvtCnt
);

   typedef enum logic {
      ST_BG  = 1'b0,
      ST_KEY = 1'b1
   } state_t;

   localparam logic [25:0] RELOAD = 26'(HOLD_CYC - 1);

   state_t      state;
   state_t      state_nxt;
   logic [25:0] cnt;
   logic [25:0] cnt_nxt;
   logic [7:0]  hist0;
   logic [7:0]  hist1;
   logic [7:0]  hist2;
   logic [7:0]  hist0_nxt;
   logic [7:0]  hist1_nxt;
   logic [7:0]  hist2_nxt;
   logic [23:0] data_nxt;
   logic [2:0]  tag_nxt;
   logic [7:0]  evt_cnt_nxt;
   logic        rpt_evt;
   logic        accept_evt;

   // A repeat still counts as keyboard activity for the hold timer.
   always_comb begin
      rpt_evt = 1'b0;
`ifdef DUP_FILTER_EN
      rpt_evt = iTrig && (state == ST_KEY) && (iData == hist0);
`endif
      accept_evt = iTrig && !rpt_evt;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= ST_BG;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Lock overrides everything; an event arriving at cnt==0 keeps KEY alive.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (iLock) begin
         state_nxt = ST_BG;
         cnt_nxt   = '0;
      end else begin
         case (state)
            ST_BG: begin
               if (accept_evt) begin
                  state_nxt = ST_KEY;
                  cnt_nxt   = RELOAD;
               end
            end
            ST_KEY: begin
               if (iTrig) begin
                  cnt_nxt = RELOAD;
               end else if (cnt != '0) begin
                  cnt_nxt = cnt - 26'd1;
               end else begin
                  state_nxt = ST_BG;
               end
            end
            default: begin
               state_nxt = ST_BG;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      hist0_nxt   = hist0;
      hist1_nxt   = hist1;
      hist2_nxt   = hist2;
      tag_nxt     = oTag;
      evt_cnt_nxt = oEvtCnt;
      if (accept_evt) begin
         hist0_nxt   = iData;
         hist1_nxt   = hist0;
         hist2_nxt   = hist1;
         tag_nxt     = iTag;
         evt_cnt_nxt = oEvtCnt + 8'd1;
      end
      // Built from next-state history so a new keycode shows on its own edge.
      if (state_nxt == ST_KEY) begin
         data_nxt = {hist2_nxt, hist1_nxt, hist0_nxt};
      end else begin
         data_nxt = iBgData;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         hist0   <= 8'h00;
         hist1   <= 8'h00;
         hist2   <= 8'h00;
         oData   <= 24'h000000;
         oTag    <= 3'b000;
         oOwner  <= 1'b0;
         oEvtCnt <= 8'h00;
      end else begin
         hist0   <= hist0_nxt;
         hist1   <= hist1_nxt;
         hist2   <= hist2_nxt;
         oData   <= data_nxt;
         oTag    <= tag_nxt;
         oOwner  <= (state_nxt == ST_KEY);
         oEvtCnt <= evt_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_smg_ctrlmod.sv
// Randomised and directed bench for ps2_smg_ctrlmod with a time-based ownership model and a scoreboard queue.
module tb_ps2_smg_ctrlmod;

   localparam int H = 8;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        iTrig = 1'b0;
   logic [7:0]  iData = 8'h00;
   logic [2:0]  iTag = 3'b000;
   logic [23:0] iBgData = 24'h000000;
   logic        iLock = 1'b0;
   logic [23:0] oData;
   logic [2:0]  oTag;
   logic        oOwner;
   logic [7:0]  oEvtCnt;

   initial forever #5 CLOCK = ~CLOCK;

   ps2_smg_ctrlmod #(.HOLD_CYC(H)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .iTrig(iTrig), .iData(iData), .iTag(iTag),
      .iBgData(iBgData), .iLock(iLock), .oData(oData), .oTag(oTag),
      .oOwner(oOwner), .oEvtCnt(oEvtCnt)
   );

   typedef struct packed {
      logic [23:0] d;
      logic [2:0]  tag;
      logic        own;
      logic [7:0]  cnt;
   } exp_t;

   exp_t  exp_q[$];
   string lbl_q[$];
   string phase = "init";
   int    vectors = 0;
   int    miscompares = 0;

   // Reference model: history as a shift list, ownership as "within H cycles of the last claim".
   logic [7:0]  mh[3];
   logic [2:0]  mtag;
   int          mcnt;
   bit          marmed;
   bit          mowner;
   int          mlast;
   int          mt;
   logic [23:0] bg_val = 24'h000000;
   logic [7:0]  last_key = 8'h00;

   task automatic step(input bit trig, input logic [7:0] d, input logic [2:0] tg,
                       input bit lk, input bit rs);
      exp_t e;
      bit rpt;
      @(negedge CLOCK);
      RESET   = rs;
      iTrig   = trig;
      iData   = d;
      iTag    = tg;
      iLock   = lk;
      iBgData = bg_val;
      mt++;
      if (rs) begin
         mh[0] = 8'h00; mh[1] = 8'h00; mh[2] = 8'h00;
         mtag = 3'b000; mcnt = 0; marmed = 1'b0; mowner = 1'b0;
         e.d = 24'h000000;
      end else begin
         rpt = 1'b0;
`ifdef DUP_FILTER_EN
         rpt = trig && mowner && (d == mh[0]);
`endif
         if (trig && !rpt) begin
            mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = d;
            mtag = tg;
            mcnt = (mcnt + 1) % 256;
         end
         if (lk) begin
            marmed = 1'b0;
         end else if (trig) begin
            marmed = 1'b1;
            mlast = mt;
         end
         mowner = marmed && ((mt - mlast) < H);
         e.d = mowner ? {mh[2], mh[1], mh[0]} : bg_val;
      end
      e.tag = mtag;
      e.own = mowner;
      e.cnt = 8'(mcnt);
      exp_q.push_back(e);
      lbl_q.push_back(phase);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic key(input logic [7:0] d, input logic [2:0] tg);
      step(1'b1, d, tg, 1'b0, 1'b0);
   endtask

   // Monitor: one registered output word per edge, checked just after the edge.
   initial begin
      exp_t e;
      exp_t got;
      string l;
      forever begin
         @(posedge CLOCK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            got = {oData, oTag, oOwner, oEvtCnt};
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL %s t=%0t got data=%h tag=%0d own=%0b cnt=%0d expected data=%h tag=%0d own=%0b cnt=%0d",
                        l, $time, got.d, got.tag, got.own, got.cnt, e.d, e.tag, e.own, e.cnt);
            end
         end
      end
   end

   initial begin
      mh[0] = 8'h00; mh[1] = 8'h00; mh[2] = 8'h00;
      mtag = 3'b000; mcnt = 0; marmed = 1'b0; mowner = 1'b0;
      mlast = -1000; mt = 0;

      phase = "reset";
      bg_val = 24'h123456;
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
      phase = "bg_idle";
      idle(3);

      phase = "single_evt";
      key(8'h1C, 3'b001);
      idle(10);

      phase = "retrigger";
      key(8'h1C, 3'b010);
      idle(6);
      key(8'h32, 3'b011);
      idle(6);
      key(8'h21, 3'b100);
      idle(6);
      key(8'h23, 3'b101);
      bg_val = 24'hABCDEF;
      idle(10);

      phase = "evt_at_cnt0";
      key(8'h44, 3'b110);
      idle(H - 1);
      key(8'h45, 3'b111);
      idle(H + 2);

      phase = "lock";
      key(8'h55, 3'b001);
      idle(2);
      bg_val = 24'h0F0F0F;
      step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      step(1'b1, 8'h1B, 3'b010, 1'b1, 1'b0);
      step(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
      idle(3);
      key(8'h66, 3'b011);
      idle(H + 2);

      phase = "wrap";
      for (int i = 0; i < 256; i++) key(8'($urandom), 3'($urandom));
      idle(3);

      phase = "reset_mid_key";
      key(8'h77, 3'b100);
      idle(2);
      step(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
      idle(2);

      phase = "repeat_keys";
      key(8'h1C, 3'b001);
      idle(3);
      key(8'h1C, 3'b010);
      idle(3);
      key(8'h1C, 3'b011);
      idle(H + 2);

      phase = "random";
      begin
         int lock_left;
         bit trig;
         bit lk;
         bit rs;
         logic [7:0] d;
         lock_left = 0;
         for (int i = 0; i < 600; i++) begin
            bg_val = 24'($urandom);
            lk = 1'b0;
            if (lock_left > 0) begin
               lk = 1'b1;
               lock_left--;
            end else if ($urandom_range(0, 40) == 0) begin
               lock_left = $urandom_range(1, 6);
            end
            trig = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 2) == 0) ? last_key : 8'($urandom);
            rs = ($urandom_range(0, 200) == 0);
            if (trig) last_key = d;
            step(trig, d, 3'($urandom), lk, rs);
         end
      end
      phase = "drain";
      idle(H + 2);

      @(negedge CLOCK);
      @(negedge CLOCK);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
